hasti_bram_ctrl_gen: RTL and testbench

Parametrised AHB-Lite (HASTI) slave that fronts a single-port, byte-writable block RAM. It generalises the fixed 32-bit controller with configurable data width, memory size and BRAM read latency. A posted-write buffer keeps writes zero-wait, and byte-accurate read-after-write forwarding covers the buffered write. It sits between the HASTI interconnect and one BRAM instance and is the memory slave in every HASTI-based SoC.

---
 rtl/hasti_pkg.sv | 39 +++
 rtl/hasti_wbuf.sv | 66 ++++++
 rtl/hasti_bram_ctrl_gen.sv | 152 +++++++++++++++
 tb/tb_hasti_bram_ctrl_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hasti_pkg.sv
// Shared HASTI (AHB-Lite) constants and the BRAM controller state encoding.
// Used by hasti_bram_ctrl_gen and hasti_wbuf.
package hasti_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  localparam logic [2:0] HSIZE_BYTE   = 3'd0;
  localparam logic [2:0] HSIZE_HWORD  = 3'd1;
  localparam logic [2:0] HSIZE_WORD   = 3'd2;
  localparam logic [2:0] HSIZE_DWORD  = 3'd3;
  localparam logic [2:0] HSIZE_4WORD  = 3'd4;
  localparam logic [2:0] HSIZE_8WORD  = 3'd5;
  localparam logic [2:0] HSIZE_16WORD = 3'd6;
  localparam logic [2:0] HSIZE_32WORD = 3'd7;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  // Unshifted byte-lane pattern for a transfer size, up to a 64-bit bus.
  function automatic logic [7:0] hsize_base_mask(input logic [2:0] size);
    logic [7:0] m;
    case (size)
      HSIZE_BYTE:  m = 8'h01;
      HSIZE_HWORD: m = 8'h03;
      HSIZE_WORD:  m = 8'h0F;
      default:     m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/hasti_wbuf.sv
// Posted-write buffer: pending word address/mask/data, read address match,
// and byte-accurate merge of buffered data into BRAM read data.
module hasti_wbuf
  import hasti_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_acc,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DATA_W/8-1:0] wr_mask,
  input  logic                rd_acc,
  input  logic [AW-1:0]       rd_addr,
  input  logic                commit,
  input  logic [DATA_W-1:0]   hwdata,
  input  logic [DATA_W-1:0]   rdata,
  output logic                pend_v,
  output logic                pend_dph,
  output logic [AW-1:0]       pend_addr,
  output logic [DATA_W/8-1:0] pend_mask,
  output logic [DATA_W-1:0]   commit_data,
  output logic [DATA_W-1:0]   hrdata
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] pend_data_q;
  logic [NB-1:0]     byp_mask_q;
  logic [DATA_W-1:0] byp_bits_c;

  // Buffer state; a new write replaces the entry in the same edge it commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_v      <= 1'b0;
      pend_dph    <= 1'b0;
      pend_addr   <= '0;
      pend_mask   <= '0;
      pend_data_q <= '0;
      byp_mask_q  <= '0;
    end else begin
      pend_dph <= wr_acc;
      if (wr_acc) begin
        pend_v    <= 1'b1;
        pend_addr <= wr_addr;
        pend_mask <= wr_mask;
      end else if (commit) begin
        pend_v <= 1'b0;
      end
      if (pend_dph) pend_data_q <= hwdata;
      if (rd_acc) byp_mask_q <= (pend_v && (pend_addr == rd_addr)) ? pend_mask : '0;
    end
  end

  // Write data is still on the bus when a back-to-back write forces an early commit.
  assign commit_data = pend_dph ? hwdata : pend_data_q;

  always_comb begin
    byp_bits_c = '0;
    for (int i = 0; i < int'(NB); i++) byp_bits_c[i*8 +: 8] = {8{byp_mask_q[i]}};
  end

  assign hrdata = (rdata & ~byp_bits_c) | (pend_data_q & byp_bits_c);

endmodule

// File: rtl/hasti_bram_ctrl_gen.sv
// Parametrised HASTI slave for a single-port byte-writable BRAM with posted writes.
// Define HASTI_BRAM_ERR_EN to enable range/size/alignment checking with ERROR responses.
module hasti_bram_ctrl_gen
  import hasti_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_BYTES = 16384,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            io_bus_haddr,
  input  logic                         io_bus_hwrite,
  input  logic [2:0]                   io_bus_hsize,
  input  logic [2:0]                   io_bus_hburst,
  input  logic [3:0]                   io_bus_hprot,
  input  logic [1:0]                   io_bus_htrans,
  input  logic                         io_bus_hmastlock,
  input  logic [DATA_W-1:0]            io_bus_hwdata,
  output logic [DATA_W-1:0]            io_bus_hrdata,
  input  logic                         io_bus_hsel,
  input  logic                         io_bus_hreadyin,
  output logic                         io_bus_hreadyout,
  output logic                         io_bus_hresp,
  output logic                         io_bram_clk,
  output logic                         io_bram_rst,
  output logic [$clog2(MEM_BYTES)-1:0] io_bram_addr,
  output logic                         io_bram_en,
  output logic [DATA_W/8-1:0]          io_bram_wmask,
  output logic [DATA_W-1:0]            io_bram_wdata,
  input  logic [DATA_W-1:0]            io_bram_rdata
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned AW = $clog2(MEM_BYTES);

  logic          xfer_c, bad_c, wr_acc_c, rd_acc_c, err_acc_c, commit_c;
  logic [AW-1:0] word_addr_c;
  logic [NB-1:0] lane_mask_c;
  logic [1:0]    state_q, state_d;
  logic          hready_q, hready_d, hresp_q, hresp_d;

  logic              pend_v, pend_dph;
  logic [AW-1:0]     pend_addr;
  logic [NB-1:0]     pend_mask;
  logic [DATA_W-1:0] commit_data;

  // Oversize transfers are treated as full-width.
  function automatic logic [NB-1:0] lane_mask(input logic [2:0] size, input logic [LB-1:0] off);
    logic [NB-1:0] m;
    if (size >= 3'(LB)) m = '1;
    else m = NB'(hsize_base_mask(size)) << off;
    return m;
  endfunction

`ifdef HASTI_BRAM_ERR_EN
  function automatic logic [ADDR_W-1:0] align_mask(input logic [2:0] size);
    return (ADDR_W'(1) << size) - ADDR_W'(1);
  endfunction
`endif

  always_comb begin
    xfer_c      = io_bus_hsel & io_bus_htrans[1] & io_bus_hreadyin & hready_q & ~reset;
    word_addr_c = {io_bus_haddr[AW-1:LB], LB'(0)};
    lane_mask_c = lane_mask(io_bus_hsize, io_bus_haddr[LB-1:0]);
    bad_c       = 1'b0;
`ifdef HASTI_BRAM_ERR_EN
    bad_c = (io_bus_haddr >= ADDR_W'(MEM_BYTES)) || (io_bus_hsize > 3'(LB)) ||
            ((io_bus_haddr & align_mask(io_bus_hsize)) != '0);
`endif
    wr_acc_c  = xfer_c & io_bus_hwrite & ~bad_c;
    rd_acc_c  = xfer_c & ~io_bus_hwrite & ~bad_c;
    err_acc_c = xfer_c & bad_c;
  end

  // Reads own the port; the buffer drains when idle or is displaced by a new write.
  always_comb begin
    commit_c      = pend_v & ~reset & ~rd_acc_c & (~pend_dph | wr_acc_c);
    io_bram_en    = rd_acc_c | commit_c;
    io_bram_addr  = rd_acc_c ? word_addr_c : pend_addr;
    io_bram_wmask = commit_c ? pend_mask : '0;
    io_bram_wdata = commit_data;
  end

  // Wait/error sequencing; only IDLE and ERR2 present hreadyout=1 and accept.
  always_comb begin
    state_d  = ST_IDLE;
    hready_d = 1'b1;
    hresp_d  = HRESP_OKAY;
    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    if (err_acc_c) state_d = ST_ERR1;
    else if (rd_acc_c && (RD_LAT == 2)) state_d = ST_WAIT;
    hready_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    hresp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
    end else begin
      state_q  <= state_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  hasti_wbuf #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_wbuf (
    .clk         (clk),
    .reset       (reset),
    .wr_acc      (wr_acc_c),
    .wr_addr     (word_addr_c),
    .wr_mask     (lane_mask_c),
    .rd_acc      (rd_acc_c),
    .rd_addr     (word_addr_c),
    .commit      (commit_c),
    .hwdata      (io_bus_hwdata),
    .rdata       (io_bram_rdata),
    .pend_v      (pend_v),
    .pend_dph    (pend_dph),
    .pend_addr   (pend_addr),
    .pend_mask   (pend_mask),
    .commit_data (commit_data),
    .hrdata      (io_bus_hrdata)
  );

  assign io_bus_hreadyout = hready_q;
  assign io_bus_hresp     = hresp_q;
  assign io_bram_clk      = clk;
  assign io_bram_rst      = reset;

  logic unused_ok;
  assign unused_ok = ^{io_bus_hburst, io_bus_hprot, io_bus_hmastlock, io_bus_htrans[0], io_bus_haddr};

`ifndef HASTI_BRAM_ERR_EN
`ifndef SYNTHESIS
  a_hsize_fits: assert property (@(posedge clk) disable iff (reset)
    !(xfer_c && (io_bus_hsize > 3'(LB))))
    else $error("HSIZE exceeds data bus width");
`endif
`endif

endmodule

// File: tb/tb_hasti_bram_ctrl_gen.sv
// Directed bench: instance A is 32-bit/RD_LAT=1, instance B is 64-bit/RD_LAT=2,
// each backed by a behavioural BRAM that counts committed writes.
module tb_hasti_bram_ctrl_gen;
  import hasti_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [63:0] hwdata;
  logic        hsel_a, hsel_b;

  logic [31:0] hrdata_a, wdata_a, rdata_a;
  logic        hready_a, hresp_a, bclk_a, brst_a, en_a;
  logic [9:0]  baddr_a;
  logic [3:0]  wmask_a;

  logic [63:0] hrdata_b, wdata_b, rdata_b, rb1;
  logic        hready_b, hresp_b, bclk_b, brst_b, en_b;
  logic [9:0]  baddr_b;
  logic [7:0]  wmask_b;

  logic [31:0] mem_a [0:255];
  logic [63:0] mem_b [0:127];
  int wr_cnt_a, wr_cnt_b;
  int n_checks, n_errors;

  always #5 clk = ~clk;

  hasti_bram_ctrl_gen #(.DATA_W(32), .MEM_BYTES(1024), .RD_LAT(1), .ADDR_W(32)) dut_a (
    .clk(clk), .reset(reset),
    .io_bus_haddr(haddr), .io_bus_hwrite(hwrite), .io_bus_hsize(hsize),
    .io_bus_hburst(3'b000), .io_bus_hprot(4'b0011), .io_bus_htrans(htrans),
    .io_bus_hmastlock(1'b0), .io_bus_hwdata(hwdata[31:0]), .io_bus_hrdata(hrdata_a),
    .io_bus_hsel(hsel_a), .io_bus_hreadyin(hready_a), .io_bus_hreadyout(hready_a),
    .io_bus_hresp(hresp_a), .io_bram_clk(bclk_a), .io_bram_rst(brst_a),
    .io_bram_addr(baddr_a), .io_bram_en(en_a), .io_bram_wmask(wmask_a),
    .io_bram_wdata(wdata_a), .io_bram_rdata(rdata_a)
  );

  hasti_bram_ctrl_gen #(.DATA_W(64), .MEM_BYTES(1024), .RD_LAT(2), .ADDR_W(32)) dut_b (
    .clk(clk), .reset(reset),
    .io_bus_haddr(haddr), .io_bus_hwrite(hwrite), .io_bus_hsize(hsize),
    .io_bus_hburst(3'b000), .io_bus_hprot(4'b0011), .io_bus_htrans(htrans),
    .io_bus_hmastlock(1'b0), .io_bus_hwdata(hwdata), .io_bus_hrdata(hrdata_b),
    .io_bus_hsel(hsel_b), .io_bus_hreadyin(hready_b), .io_bus_hreadyout(hready_b),
    .io_bus_hresp(hresp_b), .io_bram_clk(bclk_b), .io_bram_rst(brst_b),
    .io_bram_addr(baddr_b), .io_bram_en(en_b), .io_bram_wmask(wmask_b),
    .io_bram_wdata(wdata_b), .io_bram_rdata(rdata_b)
  );

  // Behavioural BRAMs: A one-cycle read, B two-cycle read.
  always @(posedge bclk_a) begin
    if (en_a) begin
      rdata_a <= mem_a[baddr_a[9:2]];
      for (int i = 0; i < 4; i++)
        if (wmask_a[i]) mem_a[baddr_a[9:2]][i*8 +: 8] <= wdata_a[i*8 +: 8];
      if (|wmask_a) wr_cnt_a <= wr_cnt_a + 1;
    end
  end

  always @(posedge bclk_b) begin
    rdata_b <= rb1;
    if (en_b) begin
      rb1 <= mem_b[baddr_b[9:3]];
      for (int i = 0; i < 8; i++)
        if (wmask_b[i]) mem_b[baddr_b[9:3]][i*8 +: 8] <= wdata_b[i*8 +: 8];
      if (|wmask_b) wr_cnt_b <= wr_cnt_b + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic bus_idle();
    hsel_a = 1'b0;
    hsel_b = 1'b0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
  endtask

  task automatic addr_ph(input logic sel_b, input logic wr, input logic [31:0] a, input logic [2:0] sz);
    hsel_a = ~sel_b;
    hsel_b = sel_b;
    htrans = HTRANS_NSEQ;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; haddr = '0; hsize = HSIZE_WORD; hwdata = '0;
    bus_idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sample();
    check("rst_hready_a", 64'(hready_a), 64'd1);
    check("rst_hresp_a", 64'(hresp_a), 64'd0);
    check("rst_en_a", 64'(en_a), 64'd0);
    check("rst_wmask_a", 64'(wmask_a), 64'd0);
    check("rst_hready_b", 64'(hready_b), 64'd1);
    check("rst_en_b", 64'(en_b), 64'd0);

    // Word write, idle, then read back
    next_cycle(); addr_ph(1'b0, 1'b1, 32'h10, HSIZE_WORD);
    next_cycle(); bus_idle(); hwdata = 64'hDEADBEEF;
    sample();
    check("wr_zero_wait", 64'(hready_a), 64'd1);
    check("no_commit_in_dphase", 64'(en_a), 64'd0);
    next_cycle(); hwdata = '0;
    sample();
    check("commit_en", 64'(en_a), 64'd1);
    check("commit_wmask", 64'(wmask_a), 64'hF);
    check("commit_wdata", 64'(wdata_a), 64'hDEADBEEF);
    next_cycle();
    next_cycle(); addr_ph(1'b0, 1'b0, 32'h10, HSIZE_WORD);
    sample();
    check("rd_addr_ready", 64'(hready_a), 64'd1);
    next_cycle(); bus_idle();
    sample();
    check("rd_data_ready", 64'(hready_a), 64'd1);
    check("rd_data", 64'(hrdata_a), 64'hDEADBEEF);
    check("single_commit", 64'(wr_cnt_a), 64'd1);

    // Byte write then immediate read of the same word: bypass merge
    next_cycle(); addr_ph(1'b0, 1'b1, 32'h10, HSIZE_WORD);
    next_cycle(); bus_idle(); hwdata = 64'h11223344;
    next_cycle();
    next_cycle();
    next_cycle(); addr_ph(1'b0, 1'b1, 32'h13, HSIZE_BYTE);
    next_cycle(); addr_ph(1'b0, 1'b0, 32'h10, HSIZE_WORD); hwdata = 64'hAB000000;
    sample();
    check("byp_rd_issue_en", 64'(en_a), 64'd1);
    check("byp_rd_issue_wmask", 64'(wmask_a), 64'd0);
    next_cycle(); bus_idle();
    sample();
    check("byp_data", 64'(hrdata_a), 64'hAB223344);
    check("byp_no_early_commit", 64'(wr_cnt_a), 64'd2);
    check("byp_commit_wmask", 64'(wmask_a), 64'h8);
    next_cycle();
    sample();
    check("byp_committed", 64'(wr_cnt_a), 64'd3);

`ifdef HASTI_BRAM_ERR_EN
    // Out-of-range read: two-cycle ERROR response
    next_cycle(); addr_ph(1'b0, 1'b0, 32'h400, HSIZE_WORD);
    next_cycle(); bus_idle();
    sample();
    check("err1_hresp", 64'(hresp_a), 64'd1);
    check("err1_hready", 64'(hready_a), 64'd0);
    check("err1_no_bram", 64'(en_a), 64'd0);
    next_cycle();
    sample();
    check("err2_hresp", 64'(hresp_a), 64'd1);
    check("err2_hready", 64'(hready_a), 64'd1);
    next_cycle();
    sample();
    check("err_done_hresp", 64'(hresp_a), 64'd0);
    check("err_done_hready", 64'(hready_a), 64'd1);
    next_cycle(); addr_ph(1'b0, 1'b1, 32'h404, HSIZE_WORD);
    next_cycle(); bus_idle(); hwdata = 64'hFFFFFFFF;
    repeat (4) next_cycle();
    sample();
    check("err_wr_untouched", 64'(wr_cnt_a), 64'd3);
    next_cycle(); addr_ph(1'b0, 1'b0, 32'h10, HSIZE_WORD);
`else
    // Out-of-range address wraps modulo the memory size
    next_cycle(); addr_ph(1'b0, 1'b0, 32'h410, HSIZE_WORD);
`endif
    next_cycle(); bus_idle();
    sample();
    check("rd_after_oob", 64'(hrdata_a), 64'hAB223344);
    check("rd_after_oob_hresp", 64'(hresp_a), 64'd0);

    // Pending write holds while reads occupy the port
    next_cycle(); addr_ph(1'b0, 1'b1, 32'h20, HSIZE_WORD);
    next_cycle(); addr_ph(1'b0, 1'b0, 32'h24, HSIZE_WORD); hwdata = 64'h0BADF00D;
    next_cycle();
    next_cycle();
    sample();
    check("hold_cnt", 64'(wr_cnt_a), 64'd3);
    check("hold_wmask", 64'(wmask_a), 64'd0);
    check("hold_ready", 64'(hready_a), 64'd1);
    next_cycle(); bus_idle();
    sample();
    check("drain_wmask", 64'(wmask_a), 64'hF);
    check("drain_addr", 64'(baddr_a), 64'h20);
    check("drain_wdata", 64'(wdata_a), 64'h0BADF00D);

    // 64-bit instance: clear a dword, then halfword write at 0x0E
    next_cycle(); addr_ph(1'b1, 1'b1, 32'h08, HSIZE_DWORD);
    next_cycle(); bus_idle(); hwdata = 64'h0;
    sample();
    check("b_wr_zero_wait", 64'(hready_b), 64'd1);
    next_cycle();
    sample();
    check("b_clr_wmask", 64'(wmask_b), 64'hFF);
    next_cycle(); addr_ph(1'b1, 1'b1, 32'h0E, HSIZE_HWORD);
    next_cycle(); bus_idle(); hwdata = 64'h5566_0000_0000_0000;
    next_cycle();
    sample();
    check("b_hw_wmask", 64'(wmask_b), 64'hC0);
    check("b_hw_wdata", 64'(wdata_b[63:48]), 64'h5566);

    // RD_LAT=2 read with a pending write draining during the wait state
    next_cycle(); addr_ph(1'b1, 1'b1, 32'h20, HSIZE_DWORD);
    next_cycle(); addr_ph(1'b1, 1'b0, 32'h08, HSIZE_DWORD); hwdata = 64'h0123456789ABCDEF;
    sample();
    check("b_rd_addr_ready", 64'(hready_b), 64'd1);
    check("b_rd_no_commit", 64'(wmask_b), 64'd0);
    next_cycle(); bus_idle();
    sample();
    check("b_wait_ready", 64'(hready_b), 64'd0);
    check("b_wait_commit", 64'(wmask_b), 64'hFF);
    check("b_wait_commit_addr", 64'(baddr_b), 64'h20);
    next_cycle();
    sample();
    check("b_data_ready", 64'(hready_b), 64'd1);
    check("b_data", hrdata_b, 64'h5566_0000_0000_0000);
    next_cycle();
    sample();
    check("b_one_wait_only", 64'(hready_b), 64'd1);
    check("b_wr_cnt", 64'(wr_cnt_b), 64'd3);

    // Reset in the data phase of a write discards it on both instances
    next_cycle(); addr_ph(1'b0, 1'b1, 32'h30, HSIZE_WORD); hsel_b = 1'b1;
    next_cycle(); bus_idle(); reset = 1'b1; hwdata = 64'hFFFF_FFFF_FFFF_FFFF;
    sample();
    check("rst_mid_en_a", 64'(en_a), 64'd0);
    check("rst_mid_brst", 64'(brst_a), 64'd1);
    next_cycle(); reset = 1'b0;
    sample();
    check("rst2_hready_a", 64'(hready_a), 64'd1);
    check("rst2_hresp_a", 64'(hresp_a), 64'd0);
    check("rst2_en_a", 64'(en_a), 64'd0);
    check("rst2_wmask_a", 64'(wmask_a), 64'd0);
    check("rst2_en_b", 64'(en_b), 64'd0);
    repeat (4) next_cycle();
    sample();
    check("rst2_no_commit_a", 64'(wr_cnt_a), 64'd4);
    check("rst2_no_commit_b", 64'(wr_cnt_b), 64'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
